l2_tlb_miss_ctrl: RTL

//  Initiator side of the L2 TLB: catches L1 ITLB/DTLB misses, arbitrates them, issues one L2

---
 rtl/l2_tlb_miss_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/l2_tlb_miss_ctrl.sv
// L2 TLB miss controller: arbitrates L1 ITLB/DTLB misses, runs one L2 lookup at a
// time and, on an L2 miss, launches a page-table walk whose result refills both
// the L2 TLB and the requesting L1 TLB.

package l2_tlb_pkg;

    localparam int unsigned VLEN   = 32;
    localparam int unsigned VPN_W  = 20;
    localparam int unsigned PPN_W  = 22;
    localparam int unsigned PERM_W = 8;

    // One TLB refill / fill payload
    typedef struct packed {
        logic              valid;
        logic [VPN_W-1:0]  vpn;
        logic [PPN_W-1:0]  ppn;
        logic [PERM_W-1:0] perm;
        logic              is_super;
    } tlb_update_t;

endpackage

module l2_tlb_miss_ctrl
    import l2_tlb_pkg::*;
#(
    parameter int unsigned STARVE_MAX   = 4,
    parameter int unsigned WALK_TIMEOUT = 1023
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              itlb_miss_i,
    input  logic [VLEN-1:0]   itlb_vaddr_i,
    input  logic              dtlb_miss_i,
    input  logic [VLEN-1:0]   dtlb_vaddr_i,
    output logic              l2_lu_valid_o,
    output logic [VLEN-1:0]   l2_lu_vaddr_o,
    output logic              l2_lu_is_itlb_o,
    input  logic              l2_hit_i,
    input  tlb_update_t       l2_update_i,
    output logic              ptw_req_valid_o,
    output logic [VLEN-1:0]   ptw_req_vaddr_o,
    output logic              ptw_req_is_itlb_o,
    input  logic              ptw_req_ready_i,
    input  tlb_update_t       ptw_update_i,
    input  logic              ptw_error_i,
    output tlb_update_t       itlb_update_o,
    output tlb_update_t       dtlb_update_o,
    output tlb_update_t       l2_fill_o,
    output logic [1:0]        miss_err_o,
    output logic              busy_o
);

    localparam int unsigned STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int unsigned TMO_W    = (WALK_TIMEOUT > 1) ? $clog2(WALK_TIMEOUT) : 1;
    localparam int unsigned TMO_LAST = (WALK_TIMEOUT > 0) ? WALK_TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WALK_REQ,
        S_WALK_WAIT,
        S_DRAIN
    } state_e;

    state_e             state_q;
    logic [VLEN-1:0]    vaddr_q;
    logic               is_itlb_q;
    logic [STARVE_W-1:0] starve_q;
    logic [TMO_W-1:0]   tmo_q;
    tlb_update_t        itlb_fill_q;
    tlb_update_t        dtlb_fill_q;
    tlb_update_t        l2_fill_q;
    logic [1:0]         err_q;

    logic               lu_fire;
    logic               req_fire;
    logic               hit_fire;
    logic               ptw_resp;
    logic               emit_pending;
    logic               starve_full;
    logic               tmo_hit;
    tlb_update_t        hit_entry;

    assign lu_fire      = (state_q == S_LOOKUP) && !flush_i;
    assign req_fire     = (state_q == S_WALK_REQ) && !flush_i;
    assign hit_fire     = lu_fire && l2_hit_i;
    assign ptw_resp     = ptw_update_i.valid || ptw_error_i;
    assign emit_pending = (|err_q) || itlb_fill_q.valid || dtlb_fill_q.valid;
    assign starve_full  = (starve_q == STARVE_W'(STARVE_MAX));
    assign tmo_hit      = (WALK_TIMEOUT != 0) && (tmo_q == TMO_W'(TMO_LAST));

    // L2 hit entry forwarded to the L1 refill port with valid forced high
    always_comb begin
        hit_entry       = l2_update_i;
        hit_entry.valid = 1'b1;
    end

    // Miss FSM: arbitration, lookup, walk request/wait, post-flush drain
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            vaddr_q     <= '0;
            is_itlb_q   <= 1'b0;
            starve_q    <= '0;
            tmo_q       <= '0;
            itlb_fill_q <= '0;
            dtlb_fill_q <= '0;
            l2_fill_q   <= '0;
            err_q       <= '0;
        end else begin
            itlb_fill_q <= '0;
            dtlb_fill_q <= '0;
            l2_fill_q   <= '0;
            err_q       <= '0;

            case (state_q)
                S_IDLE: begin
                    // Requesters still see last cycle's refill/err, so no grant yet
                    if (!flush_i && !emit_pending) begin
                        if (itlb_miss_i && (!dtlb_miss_i || starve_full)) begin
                            vaddr_q   <= itlb_vaddr_i;
                            is_itlb_q <= 1'b1;
                            starve_q  <= '0;
                            state_q   <= S_LOOKUP;
                        end else if (dtlb_miss_i) begin
                            vaddr_q   <= dtlb_vaddr_i;
                            is_itlb_q <= 1'b0;
                            if (itlb_miss_i && !starve_full) begin
                                starve_q <= starve_q + STARVE_W'(1);
                            end
                            state_q   <= S_LOOKUP;
                        end
                    end
                end

                S_LOOKUP: begin
                    if (flush_i || l2_hit_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_WALK_REQ;
                    end
                end

                S_WALK_REQ: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else if (ptw_req_ready_i) begin
                        tmo_q   <= '0;
                        state_q <= S_WALK_WAIT;
                    end
                end

                S_WALK_WAIT: begin
                    if (flush_i) begin
                        // A result arriving with the flush is simply discarded
                        state_q <= ptw_resp ? S_IDLE : S_DRAIN;
                    end else if (ptw_error_i) begin
                        err_q   <= {is_itlb_q, !is_itlb_q};
                        state_q <= S_IDLE;
                    end else if (ptw_update_i.valid) begin
                        l2_fill_q <= ptw_update_i;
                        if (is_itlb_q) begin
                            itlb_fill_q <= ptw_update_i;
                        end else begin
                            dtlb_fill_q <= ptw_update_i;
                        end
                        state_q <= S_IDLE;
                    end else if (tmo_hit) begin
                        err_q   <= {is_itlb_q, !is_itlb_q};
                        state_q <= S_DRAIN;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end

                S_DRAIN: begin
                    if (ptw_resp) begin
                        state_q <= S_IDLE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign l2_lu_valid_o     = lu_fire;
    assign l2_lu_vaddr_o     = lu_fire ? vaddr_q : '0;
    assign l2_lu_is_itlb_o   = lu_fire && is_itlb_q;

    assign ptw_req_valid_o   = req_fire;
    assign ptw_req_vaddr_o   = req_fire ? vaddr_q : '0;
    assign ptw_req_is_itlb_o = req_fire && is_itlb_q;

    assign itlb_update_o     = (hit_fire && is_itlb_q)  ? hit_entry : itlb_fill_q;
    assign dtlb_update_o     = (hit_fire && !is_itlb_q) ? hit_entry : dtlb_fill_q;
    assign l2_fill_o         = l2_fill_q;
    assign miss_err_o        = err_q;
    assign busy_o            = (state_q != S_IDLE);

endmodule
